// File: rtl/of_ex_latch_if.sv
`default_nettype none
// ============================================================================
// Module  : of_ex_latch_if
// Brief   : OF->EX pipeline bundle (operands, control, forwarding, EX outputs)
// Revision: 1.0  initial release
// ============================================================================
interface of_ex_latch_if #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic                  stall;
    logic                  flush;
    logic                  in_valid;
    logic [31:0]           in_pc;
    logic [31:0]           in_A;
    logic [31:0]           in_B;
    logic [31:0]           in_op2;
    logic [31:0]           in_immx;
    logic                  in_isImmediate;
    logic [12:0]           in_aluSignals;
    logic [REG_ADDR_W-1:0] in_rs1;
    logic [REG_ADDR_W-1:0] in_rs2;
    logic [REG_ADDR_W-1:0] in_rst;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  in_wb;
    logic                  ma_fwd_en;
    logic [REG_ADDR_W-1:0] ma_fwd_rd;
    logic [31:0]           ma_fwd_data;
    logic                  rw_fwd_en;
    logic [REG_ADDR_W-1:0] rw_fwd_rd;
    logic [31:0]           rw_fwd_data;

    logic                  valid;
    logic [31:0]           pc;
    logic [31:0]           A_ALU;
    logic [31:0]           B_ALU;
    logic [31:0]           op2;
    logic [31:0]           immx;
    logic                  isImmediate;
    logic [12:0]           aluSignals;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wb;
    logic [CNT_W-1:0]      bubble_count;

    modport master (
        output stall, flush, in_valid, in_pc, in_A, in_B, in_op2, in_immx,
               in_isImmediate, in_aluSignals, in_rs1, in_rs2, in_rst, in_rd,
               in_wb, ma_fwd_en, ma_fwd_rd, ma_fwd_data, rw_fwd_en, rw_fwd_rd,
               rw_fwd_data,
        input  valid, pc, A_ALU, B_ALU, op2, immx, isImmediate, aluSignals,
               rd, wb, bubble_count
    );

    modport slave (
        input  stall, flush, in_valid, in_pc, in_A, in_B, in_op2, in_immx,
               in_isImmediate, in_aluSignals, in_rs1, in_rs2, in_rst, in_rd,
               in_wb, ma_fwd_en, ma_fwd_rd, ma_fwd_data, rw_fwd_en, rw_fwd_rd,
               rw_fwd_data,
        output valid, pc, A_ALU, B_ALU, op2, immx, isImmediate, aluSignals,
               rd, wb, bubble_count
    );
endinterface
`default_nettype wire

// File: rtl/of_ex_latch.sv
`default_nettype none
// ============================================================================
// Module  : of_ex_latch
// Brief   : OF/EX pipeline register with MA/RW forwarding, stall, flush and
//           a saturating bubble counter
// Revision: 1.0  initial release
// ============================================================================
module of_ex_latch #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    of_ex_latch_if.slave     bus
);

    // MA is the younger producer, so it wins over RW on a shared destination.
    function automatic logic [31:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic [31:0]           rf_val,
        input logic                  ma_en,
        input logic [REG_ADDR_W-1:0] ma_rd,
        input logic [31:0]           ma_data,
        input logic                  rw_en,
        input logic [REG_ADDR_W-1:0] rw_rd,
        input logic [31:0]           rw_data
    );
        if (ma_en && (ma_rd == src))
            return ma_data;
        else if (rw_en && (rw_rd == src))
            return rw_data;
        else
            return rf_val;
    endfunction

    logic [31:0] w_fwd_a;
    logic [31:0] w_fwd_b;
    logic [31:0] w_fwd_op2;
    logic        w_bubble;

    always_comb begin
        w_fwd_a   = fwd_sel(bus.in_rs1, bus.in_A, bus.ma_fwd_en, bus.ma_fwd_rd,
                            bus.ma_fwd_data, bus.rw_fwd_en, bus.rw_fwd_rd, bus.rw_fwd_data);
        w_fwd_b   = fwd_sel(bus.in_rs2, bus.in_B, bus.ma_fwd_en, bus.ma_fwd_rd,
                            bus.ma_fwd_data, bus.rw_fwd_en, bus.rw_fwd_rd, bus.rw_fwd_data);
        w_fwd_op2 = fwd_sel(bus.in_rst, bus.in_op2, bus.ma_fwd_en, bus.ma_fwd_rd,
                            bus.ma_fwd_data, bus.rw_fwd_en, bus.rw_fwd_rd, bus.rw_fwd_data);
        // Flush beats stall; an empty OF slot only becomes a bubble when not stalled.
        w_bubble  = bus.flush || (!bus.stall && !bus.in_valid);
    end

    logic                  r_valid;
    logic [31:0]           r_pc;
    logic [31:0]           r_a_alu;
    logic [31:0]           r_b_alu;
    logic [31:0]           r_op2;
    logic [31:0]           r_immx;
    logic                  r_is_imm;
    logic [12:0]           r_alu_signals;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_wb;
    logic [CNT_W-1:0]      r_bubble_count;

    always_ff @(posedge clk) begin
        if (reset || w_bubble) begin
            r_valid       <= 1'b0;
            r_pc          <= '0;
            r_a_alu       <= '0;
            r_b_alu       <= '0;
            r_op2         <= '0;
            r_immx        <= '0;
            r_is_imm      <= 1'b0;
            r_alu_signals <= '0;
            r_rd          <= '0;
            r_wb          <= 1'b0;
        end else if (!bus.stall) begin
            r_valid       <= 1'b1;
            r_pc          <= bus.in_pc;
            r_a_alu       <= w_fwd_a;
            r_b_alu       <= w_fwd_b;
            r_op2         <= w_fwd_op2;
            r_immx        <= bus.in_immx;
            r_is_imm      <= bus.in_isImmediate;
            r_alu_signals <= bus.in_aluSignals;
            r_rd          <= bus.in_rd;
            r_wb          <= bus.in_wb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_bubble_count <= '0;
        else if (w_bubble && (r_bubble_count != {CNT_W{1'b1}}))
            r_bubble_count <= r_bubble_count + 1'b1;
    end

    assign bus.valid        = r_valid;
    assign bus.pc           = r_pc;
    assign bus.A_ALU        = r_a_alu;
    assign bus.B_ALU        = r_b_alu;
    assign bus.op2          = r_op2;
    assign bus.immx         = r_immx;
    assign bus.isImmediate  = r_is_imm;
    assign bus.aluSignals   = r_alu_signals;
    assign bus.rd           = r_rd;
    assign bus.wb           = r_wb;
    assign bus.bubble_count = r_bubble_count;

endmodule
`default_nettype wire

// File: tb/tb_of_ex_latch.sv
`default_nettype none
// ============================================================================
// Module  : tb_of_ex_latch
// Brief   : directed vector bench for of_ex_latch (16-bit and 4-bit counters)
// Revision: 1.0  initial release
// ============================================================================
module tb_of_ex_latch;

    typedef struct {
        logic        stall, flush, vld;
        logic [31:0] pc, a, b, o, imm;
        logic        isimm;
        logic [12:0] alu;
        logic [3:0]  rs1, rs2, rst, rd;
        logic        wb;
        logic        ma_en;
        logic [3:0]  ma_rd;
        logic [31:0] ma_d;
        logic        rw_en;
        logic [3:0]  rw_rd;
        logic [31:0] rw_d;
        logic        x_valid;
        logic [31:0] x_pc, x_a, x_b, x_o, x_imm;
        logic        x_isimm;
        logic [12:0] x_alu;
        logic [3:0]  x_rd;
        logic        x_wb;
        logic [15:0] x_bc;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    of_ex_latch_if #(.REG_ADDR_W(4), .CNT_W(16)) bus ();
    of_ex_latch_if #(.REG_ADDR_W(4), .CNT_W(4))  sat ();

    of_ex_latch #(.REG_ADDR_W(4), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    of_ex_latch #(.REG_ADDR_W(4), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sat.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkld(
        input logic [31:0] pc, a, b, o,
        input logic [3:0]  rs1, rs2, rst,
        input logic        ma_en, input logic [3:0] ma_rd, input logic [31:0] ma_d,
        input logic        rw_en, input logic [3:0] rw_rd, input logic [31:0] rw_d,
        input logic [31:0] xa, xb, xo,
        input logic [15:0] bc
    );
        vec_t v;
        v.stall = 1'b0; v.flush = 1'b0; v.vld = 1'b1;
        v.pc = pc; v.a = a; v.b = b; v.o = o;
        v.imm = 32'hFFFF_FF80; v.isimm = 1'b1; v.alu = 13'h010;
        v.rs1 = rs1; v.rs2 = rs2; v.rst = rst; v.rd = 4'd7; v.wb = 1'b1;
        v.ma_en = ma_en; v.ma_rd = ma_rd; v.ma_d = ma_d;
        v.rw_en = rw_en; v.rw_rd = rw_rd; v.rw_d = rw_d;
        v.x_valid = 1'b1; v.x_pc = pc; v.x_a = xa; v.x_b = xb; v.x_o = xo;
        v.x_imm = 32'hFFFF_FF80; v.x_isimm = 1'b1; v.x_alu = 13'h010;
        v.x_rd = 4'd7; v.x_wb = 1'b1; v.x_bc = bc;
        return v;
    endfunction

    function automatic vec_t mkbub(input logic stall, flush, vld, input logic [15:0] bc);
        vec_t v;
        v = mkld(32'hDEAD_0000, 32'h1, 32'h2, 32'h3, 4'd1, 4'd2, 4'd3,
                 1'b1, 4'd1, 32'hAB, 1'b1, 4'd2, 32'hCD, 32'h0, 32'h0, 32'h0, bc);
        v.stall = stall; v.flush = flush; v.vld = vld;
        v.x_valid = 1'b0; v.x_pc = '0; v.x_imm = '0; v.x_isimm = 1'b0;
        v.x_alu = '0; v.x_rd = '0; v.x_wb = 1'b0;
        return v;
    endfunction

    // Stalled entry: new stimulus, but expectations carried over from h.
    function automatic vec_t mkhold(input vec_t v, input vec_t h);
        vec_t r;
        r = v;
        r.stall = 1'b1;
        r.x_valid = h.x_valid; r.x_pc = h.x_pc; r.x_a = h.x_a; r.x_b = h.x_b;
        r.x_o = h.x_o; r.x_imm = h.x_imm; r.x_isimm = h.x_isimm; r.x_alu = h.x_alu;
        r.x_rd = h.x_rd; r.x_wb = h.x_wb; r.x_bc = h.x_bc;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        bus.stall = v.stall; bus.flush = v.flush; bus.in_valid = v.vld;
        bus.in_pc = v.pc; bus.in_A = v.a; bus.in_B = v.b; bus.in_op2 = v.o;
        bus.in_immx = v.imm; bus.in_isImmediate = v.isimm; bus.in_aluSignals = v.alu;
        bus.in_rs1 = v.rs1; bus.in_rs2 = v.rs2; bus.in_rst = v.rst;
        bus.in_rd = v.rd; bus.in_wb = v.wb;
        bus.ma_fwd_en = v.ma_en; bus.ma_fwd_rd = v.ma_rd; bus.ma_fwd_data = v.ma_d;
        bus.rw_fwd_en = v.rw_en; bus.rw_fwd_rd = v.rw_rd; bus.rw_fwd_data = v.rw_d;
    endtask

    task automatic expect_vec(input vec_t v, input string tag);
        check({tag, ".valid"},  {31'd0, bus.valid},       {31'd0, v.x_valid});
        check({tag, ".pc"},     bus.pc,                   v.x_pc);
        check({tag, ".A_ALU"},  bus.A_ALU,                v.x_a);
        check({tag, ".B_ALU"},  bus.B_ALU,                v.x_b);
        check({tag, ".op2"},    bus.op2,                  v.x_o);
        check({tag, ".immx"},   bus.immx,                 v.x_imm);
        check({tag, ".isImm"},  {31'd0, bus.isImmediate}, {31'd0, v.x_isimm});
        check({tag, ".alu"},    {19'd0, bus.aluSignals},  {19'd0, v.x_alu});
        check({tag, ".rd"},     {28'd0, bus.rd},          {28'd0, v.x_rd});
        check({tag, ".wb"},     {31'd0, bus.wb},          {31'd0, v.x_wb});
        check({tag, ".bcount"}, {16'd0, bus.bubble_count}, {16'd0, v.x_bc});
    endtask

    vec_t tbl[$];
    vec_t v;
    vec_t held;
    vec_t zero;

    initial begin
        n_checks = 0;
        n_errors = 0;
        sat.stall = 1'b0; sat.flush = 1'b0; sat.in_valid = 1'b0;
        sat.in_pc = '0; sat.in_A = '0; sat.in_B = '0; sat.in_op2 = '0; sat.in_immx = '0;
        sat.in_isImmediate = 1'b0; sat.in_aluSignals = '0;
        sat.in_rs1 = '0; sat.in_rs2 = '0; sat.in_rst = '0; sat.in_rd = '0; sat.in_wb = 1'b0;
        sat.ma_fwd_en = 1'b0; sat.ma_fwd_rd = '0; sat.ma_fwd_data = '0;
        sat.rw_fwd_en = 1'b0; sat.rw_fwd_rd = '0; sat.rw_fwd_data = '0;

        // Reset with a live instruction and arbitrary operands on the inputs.
        reset = 1'b1;
        v = mkld($urandom, $urandom, $urandom, $urandom, 4'($urandom), 4'($urandom),
                 4'($urandom), 1'b1, 4'($urandom), $urandom, 1'b1, 4'($urandom),
                 $urandom, '0, '0, '0, '0);
        drive(v);
        repeat (2) @(posedge clk);
        #1;
        zero = mkbub(1'b0, 1'b0, 1'b0, 16'd0);
        zero.x_a = '0; zero.x_b = '0; zero.x_o = '0;
        expect_vec(zero, "reset");
        check("reset.sat_bcount", {28'd0, sat.bubble_count}, 32'd0);
        reset = 1'b0;

        // First load after reset release.
        v = mkld(32'h10, 32'h0, 32'h0, 32'h0, 4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 32'h0,
                 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd0);
        v.alu = 13'h001; v.x_alu = 13'h001;
        tbl.push_back(v);
        for (int k = 1; k <= 5; k++)
            tbl.push_back(mkbub(1'b0, 1'b0, 1'b0, 16'(k)));
        // rs1 -> A_ALU
        tbl.push_back(mkld(32'h30, 32'h11, 32'h22, 32'h33, 4'd3, 4'd4, 4'd5, 1'b1, 4'd3, 32'hAA,
                           1'b1, 4'd3, 32'hBB, 32'hAA, 32'h22, 32'h33, 16'd5));
        tbl.push_back(mkld(32'h34, 32'h11, 32'h22, 32'h33, 4'd3, 4'd4, 4'd5, 1'b0, 4'd3, 32'hAA,
                           1'b1, 4'd3, 32'hBB, 32'hBB, 32'h22, 32'h33, 16'd5));
        tbl.push_back(mkld(32'h38, 32'h11, 32'h22, 32'h33, 4'd3, 4'd4, 4'd5, 1'b0, 4'd3, 32'hAA,
                           1'b0, 4'd3, 32'hBB, 32'h11, 32'h22, 32'h33, 16'd5));
        // rs2 -> B_ALU (isImmediate=1 here, B still forwarded)
        tbl.push_back(mkld(32'h40, 32'h11, 32'h22, 32'h33, 4'd4, 4'd3, 4'd5, 1'b1, 4'd3, 32'hAA,
                           1'b1, 4'd3, 32'hBB, 32'h11, 32'hAA, 32'h33, 16'd5));
        tbl.push_back(mkld(32'h44, 32'h11, 32'h22, 32'h33, 4'd4, 4'd3, 4'd5, 1'b0, 4'd3, 32'hAA,
                           1'b1, 4'd3, 32'hBB, 32'h11, 32'hBB, 32'h33, 16'd5));
        tbl.push_back(mkld(32'h48, 32'h11, 32'h22, 32'h33, 4'd4, 4'd3, 4'd5, 1'b0, 4'd3, 32'hAA,
                           1'b0, 4'd3, 32'hBB, 32'h11, 32'h22, 32'h33, 16'd5));
        // rst -> op2
        tbl.push_back(mkld(32'h50, 32'h11, 32'h22, 32'h33, 4'd4, 4'd5, 4'd3, 1'b1, 4'd3, 32'hAA,
                           1'b1, 4'd3, 32'hBB, 32'h11, 32'h22, 32'hAA, 16'd5));
        tbl.push_back(mkld(32'h54, 32'h11, 32'h22, 32'h33, 4'd4, 4'd5, 4'd3, 1'b0, 4'd3, 32'hAA,
                           1'b1, 4'd3, 32'hBB, 32'h11, 32'h22, 32'hBB, 16'd5));
        tbl.push_back(mkld(32'h58, 32'h11, 32'h22, 32'h33, 4'd4, 4'd5, 4'd3, 1'b0, 4'd3, 32'hAA,
                           1'b0, 4'd3, 32'hBB, 32'h11, 32'h22, 32'h33, 16'd5));
        // Distinct MA and RW destinations feeding different sources.
        tbl.push_back(mkld(32'h5C, 32'h11, 32'h22, 32'h33, 4'd3, 4'd4, 4'd0, 1'b1, 4'd3, 32'hAA,
                           1'b1, 4'd4, 32'hBB, 32'hAA, 32'hBB, 32'h33, 16'd5));
        // Load then hold for three stalled cycles with changing stimulus.
        held = mkld(32'h20, 32'h5, 32'h6, 32'h7, 4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 32'h0,
                    1'b0, 4'd0, 32'h0, 32'h5, 32'h6, 32'h7, 16'd5);
        tbl.push_back(held);
        for (int k = 0; k < 3; k++)
            tbl.push_back(mkhold(mkld(32'h900 + 32'(k), 32'h77 + 32'(k), 32'h88, 32'h99, 4'd1, 4'd2,
                                      4'd3, 1'b1, 4'd1, 32'hEE, 1'b1, 4'd2, 32'hFF,
                                      32'h0, 32'h0, 32'h0, 16'd0), held));
        tbl.push_back(mkhold(mkbub(1'b1, 1'b0, 1'b0, 16'd0), held));
        // Flush wins over stall while a valid instruction is offered.
        tbl.push_back(mkbub(1'b1, 1'b1, 1'b1, 16'd6));
        // Back-to-back dependency on MA result.
        v = mkld(32'h64, 32'h888, 32'h999, 32'h0, 4'd2, 4'd2, 4'd0, 1'b1, 4'd2, 32'h1234,
                 1'b0, 4'd0, 32'h0, 32'h1234, 32'h1234, 32'h0, 16'd6);
        v.isimm = 1'b0; v.x_isimm = 1'b0;
        tbl.push_back(v);

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            expect_vec(tbl[i], $sformatf("v%0d", i));
        end

        // Reset during stall, then reset during flush: both clear everything.
        bus.stall = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        expect_vec(zero, "rst_stall");
        bus.stall = 1'b0;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        expect_vec(zero, "rst_flush");
        reset = 1'b0;
        v = mkld(32'h44, 32'h1, 32'h2, 32'h3, 4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 32'h0,
                 1'b0, 4'd0, 32'h0, 32'h1, 32'h2, 32'h3, 16'd0);
        drive(v);
        @(posedge clk);
        #1;
        expect_vec(v, "post_rst");

        // Saturation: 20 bubbles into both counters from a fresh reset.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 15 || k == 20) begin
                check($sformatf("sat_bcount@%0d", k), {28'd0, sat.bubble_count}, 32'd15);
                check($sformatf("bcount@%0d", k), {16'd0, bus.bubble_count}, 32'(k));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/of_ex_latch.md
Name: of_ex_latch

Overview:
- Pipeline register between Operand Fetch (OF) and Execute (EX) in the SimpleRISC 5-stage pipeline.
- Captures decoded operands and control for the instruction entering EX, and feeds the ALU unit directly: A_ALU, B_ALU, immx, isImmediate, aluSignals.
- Resolves RAW hazards by forwarding from the MA and RW stages at capture time.
- Supports stall (hold), flush (bubble insertion), and a saturating bubble counter for performance debug.

Parameters:
- REG_ADDR_W, 4, register-file address width (16 GPRs; r0 is a normal register, not hard-wired zero)
- CNT_W, 16, width of the bubble counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold all latched contents this cycle
- flush  input  1  replace latched instruction with a bubble (branch mispredict)
- in_valid  input  1  OF holds a real instruction
- in_pc  input  32  PC of OF instruction
- in_A  input  32  rs1 value read from register file
- in_B  input  32  rs2 value read from register file
- in_op2  input  32  store-data register value (rd for st)
- in_immx  input  32  sign/zero-extended immediate
- in_isImmediate  input  1  B operand is the immediate
- in_aluSignals  input  13  one-hot ALU op select
- in_rs1, in_rs2, in_rst  input  REG_ADDR_W  source addresses for A, B, op2
- in_rd  input  REG_ADDR_W  destination register
- in_wb  input  1  instruction writes the register file
- ma_fwd_en  input  1  MA-stage instruction writes a register
- ma_fwd_rd  input  REG_ADDR_W  MA destination
- ma_fwd_data  input  32  MA result
- rw_fwd_en, rw_fwd_rd, rw_fwd_data  input  1/REG_ADDR_W/32  same, RW stage
- valid  output  1  EX holds a real instruction
- pc  output  32
- A_ALU, B_ALU, op2, immx  output  32  to ALU / MA
- isImmediate  output  1
- aluSignals  output  13
- rd  output  REG_ADDR_W
- wb  output  1
- bubble_count  output  CNT_W  cycles in which a bubble was loaded

Behaviour:
- All outputs are registered and update only on the rising clk edge.
- Priority per cycle: reset > flush > stall > load.
- reset: every output is cleared to 0, including valid, wb, aluSignals, and bubble_count.
- flush: valid, wb, and aluSignals are set to 0; all data fields are set to 0; bubble_count increments. Flush overrides a simultaneous stall.
- stall (no flush): every output holds its value, including bubble_count. Forwarding inputs are ignored.
- load with in_valid=1: all fields capture their in_* values, with forwarding applied to A_ALU, B_ALU, and op2.
- load with in_valid=0: same as flush (bubble, counter increments).
- Forwarding, evaluated combinationally on in_* at the capture edge, independently for each of rs1→A_ALU, rs2→B_ALU, rst→op2:
  - If ma_fwd_en and ma_fwd_rd == src, take ma_fwd_data.
  - Else if rw_fwd_en and rw_fwd_rd == src, take rw_fwd_data.
  - Else take the register-file value.
  - MA has priority over RW because it is younger.
- B_ALU is forwarded even when in_isImmediate=1. The ALU selects immx itself; the forwarded B is harmless.
- Latency: one cycle from OF inputs to EX outputs.
- bubble_count saturates at all-ones and does not wrap.
- Reset asserted mid-stall or mid-flush clears everything on that edge. The first load is accepted on the edge after reset deasserts.
- aluSignals passes through unmodified; this block does not check one-hotness.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1 and random inputs → all outputs 0, bubble_count=0. Release → next edge loads in_pc=0x10, in_aluSignals=13'h001, valid=1.
- Forwarding priority: in_rs1=3, in_A=0x11, ma_fwd(en,3,0xAA), rw_fwd(en,3,0xBB) → A_ALU=0xAA. Drop ma_fwd_en → A_ALU=0xBB. Drop both → 0x11. Repeat the same checks for rs2→B_ALU and rst→op2.
- Stall: load pc=0x20 and A=5, then assert stall 3 cycles while changing all in_* and fwd inputs → outputs stay pc=0x20, A_ALU=5, bubble_count unchanged.
- Flush with stall: stall=1, flush=1 while holding a valid instruction → valid=0, wb=0, aluSignals=0, bubble_count+1.
- Bubble count: drive in_valid=0 for 5 cycles → bubble_count=5. Preload a counter near saturation (CNT_W=4 build, 20 bubbles) → count stops at 15.
- Back-to-back dependency: instr1 (rd=2, wb=1) in MA with result 0x1234, instr2 in OF with rs1=2, rs2=2, in_isImmediate=0 → A_ALU=B_ALU=0x1234 on the next edge.
